// File: rtl/axi_bridge.sv
// axi_bridge: sram-like inst/data requests to a single-outstanding-read, single-outstanding-write AXI master.
// The data read path and the write path run concurrently; a data read that hits a pending write waits.
module axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;
    r_state_t    r_state;
    w_state_t    w_state;
    logic [31:0] r_addr, w_addr, w_data;
    logic [1:0]  r_size, w_size;
    logic [3:0]  w_strb;
    logic        r_id, aw_done, w_done;
    logic        wr_hit, data_rd_go, inst_rd_go, data_wr_go, r_beat, data_r_beat;
    logic        unused_ok;
    assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};
    assign wr_hit      = w_state != W_IDLE && data_sram_addr[31:2] == w_addr[31:2];
    assign data_rd_go  = !reset && r_state == R_IDLE && data_sram_req && !data_sram_wr && !wr_hit;
    assign inst_rd_go  = !reset && r_state == R_IDLE && inst_sram_req && !inst_sram_wr && !data_rd_go;
    assign data_wr_go  = !reset && w_state == W_IDLE && data_sram_req && data_sram_wr;
    assign arvalid     = !reset && r_state == R_AR;
    assign rready      = !reset && r_state == R_R;
    assign awvalid     = !reset && w_state == W_REQ && !aw_done;
    assign wvalid      = !reset && w_state == W_REQ && !w_done;
    assign r_beat      = rvalid && rready;
    assign data_r_beat = r_beat && rid == 4'd1;
    // Hold off the B handshake when a data R beat already owns data_sram_data_ok this cycle
    assign bready      = !reset && w_state == W_B && !data_r_beat;
    assign inst_sram_addr_ok = inst_rd_go;
    assign data_sram_addr_ok = data_rd_go || data_wr_go;
    assign inst_sram_data_ok = r_beat && rid != 4'd1;
    assign data_sram_data_ok = data_r_beat || (bvalid && bready);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;
    assign arid    = {3'b000, r_id};
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = 4'd1;
    assign awaddr  = w_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, w_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wdata   = w_data;
    assign wstrb   = w_strb;
    assign wlast   = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (data_rd_go || inst_rd_go) begin
                    r_state <= R_AR;
                    r_addr  <= data_rd_go ? data_sram_addr : inst_sram_addr;
                    r_size  <= data_rd_go ? data_sram_size : inst_sram_size;
                    r_id    <= data_rd_go;
                end
                R_AR:    if (arready) r_state <= R_R;
                R_R:     if (rvalid) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_size  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (data_wr_go) begin
                    w_state <= W_REQ;
                    w_addr  <= data_sram_addr;
                    w_data  <= data_sram_wdata;
                    w_strb  <= data_sram_wstrb;
                    w_size  <= data_sram_size;
                end
                W_REQ: begin
                    aw_done <= aw_done || awready;
                    w_done  <= w_done || wready;
                    if ((aw_done || awready) && (w_done || wready)) begin
                        w_state <= W_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                W_B:     if (bvalid && bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_bridge.sv
// tb_axi_bridge: directed read-transaction table plus hand-written write, hazard, collision and reset sequences.
module tb_axi_bridge;
    logic        clk = 0, reset = 1;
    logic        inst_sram_req = 0, inst_sram_wr = 0;
    logic [1:0]  inst_sram_size = 2;
    logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0;
    logic [3:0]  inst_sram_wstrb = 0;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req = 0, data_sram_wr = 0;
    logic [1:0]  data_sram_size = 2;
    logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
    logic [3:0]  data_sram_wstrb = 0;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, awcache, arcache, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready = 0, rlast = 1, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 1;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    int checks = 0, errors = 0;

    axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after negedge; outputs are sampled 1ns later, well away from posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    typedef struct {
        logic        side;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] rdat;
        int          ar_wait;
        int          r_wait;
        logic [3:0]  exp_id;
        logic [2:0]  exp_size;
    } rvec_t;

    task automatic rd(input rvec_t v);
        cyc();
        if (v.side) begin
            data_sram_req = 1; data_sram_wr = 0; data_sram_addr = v.addr; data_sram_size = v.size;
        end else begin
            inst_sram_req = 1; inst_sram_wr = 0; inst_sram_addr = v.addr; inst_sram_size = v.size;
        end
        #1 chk("rd addr_ok", v.side ? data_sram_addr_ok : inst_sram_addr_ok, 1);
        chk("rd arvalid early", arvalid, 0);
        for (int i = 0; i <= v.ar_wait; i++) begin
            cyc();
            inst_sram_req = 0; data_sram_req = 0;
            data_sram_addr = 32'hDEAD_BEE0; inst_sram_addr = 32'hDEAD_BEE0;
            arready = (i == v.ar_wait);
            #1 chk("rd arvalid", arvalid, 1);
            chk("rd araddr", araddr, v.addr);
            chk("rd arid", arid, v.exp_id);
            chk("rd arsize", arsize, v.exp_size);
        end
        for (int i = 0; i <= v.r_wait; i++) begin
            cyc();
            arready = 0;
            rvalid = (i == v.r_wait); rid = v.exp_id; rdata = v.rdat;
            #1 chk("rd rready", rready, 1);
            chk("rd data_ok", v.side ? data_sram_data_ok : inst_sram_data_ok, rvalid);
            chk("rd other data_ok", v.side ? inst_sram_data_ok : data_sram_data_ok, 0);
        end
        chk("rd rdata", v.side ? data_sram_rdata : inst_sram_rdata, v.rdat);
        cyc();
        rvalid = 0;
        #1 chk("rd idle rready", rready, 0);
        chk("rd idle arvalid", arvalid, 0);
    endtask

    rvec_t tbl[4];

    initial begin
        tbl[0] = '{1'b0, 32'h1C00_0000, 2'd2, 32'h0280_0C0C, 0, 2, 4'd0, 3'd2};
        tbl[1] = '{1'b1, 32'h1C00_1234, 2'd1, 32'hCAFE_F00D, 2, 0, 4'd1, 3'd1};
        tbl[2] = '{1'b0, 32'h1FC0_0004, 2'd0, 32'h0000_00A5, 1, 1, 4'd0, 3'd0};
        tbl[3] = '{1'b1, 32'hBFAF_FFF8, 2'd2, 32'h8000_0001, 0, 0, 4'd1, 3'd2};

        cyc();
        inst_sram_req = 1; data_sram_req = 1; rvalid = 1; bvalid = 1;
        #1 chk("reset inst addr_ok", inst_sram_addr_ok, 0);
        chk("reset data addr_ok", data_sram_addr_ok, 0);
        chk("reset arvalid", arvalid, 0);
        chk("reset rready", rready, 0);
        chk("reset awvalid", awvalid, 0);
        chk("reset wvalid", wvalid, 0);
        chk("reset bready", bready, 0);
        chk("reset data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
        chk("fixed fields", {arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot, awid, wid, wlast},
            {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 4'd1, 1'b1});
        cyc();
        inst_sram_req = 0; data_sram_req = 0; rvalid = 0; bvalid = 0;
        cyc();
        reset = 0;

        cyc();
        inst_sram_req = 1; inst_sram_wr = 1;
        #1 chk("inst write addr_ok", inst_sram_addr_ok, 0);
        cyc();
        inst_sram_req = 0; inst_sram_wr = 0;
        #1 chk("inst write no arvalid", arvalid, 0);
        chk("inst write no awvalid", awvalid, 0);

        foreach (tbl[k]) rd(tbl[k]);

        // Simultaneous inst and data read: data wins, inst waits for the data R beat
        cyc();
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_0080;
        #1 chk("both data addr_ok", data_sram_addr_ok, 1);
        chk("both inst addr_ok", inst_sram_addr_ok, 0);
        cyc();
        data_sram_req = 0; arready = 1;
        #1 chk("both arid", arid, 1);
        chk("both araddr", araddr, 32'h1C00_0080);
        chk("both inst wait ar", inst_sram_addr_ok, 0);
        cyc();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h1111_2222;
        #1 chk("both data data_ok", data_sram_data_ok, 1);
        chk("both inst wait r", inst_sram_addr_ok, 0);
        chk("both data rdata", data_sram_rdata, 32'h1111_2222);
        cyc();
        rvalid = 0;
        #1 chk("both inst addr_ok late", inst_sram_addr_ok, 1);
        cyc();
        inst_sram_req = 0; arready = 1;
        #1 chk("both inst arid", arid, 0);
        chk("both inst araddr", araddr, 32'h1C00_0040);
        cyc();
        arready = 0; rvalid = 1; rid = 0; rdata = 32'h3333_4444;
        #1 chk("both inst data_ok", inst_sram_data_ok, 1);
        cyc();
        rvalid = 0;

        // Data write with awready immediate and wready two cycles late
        cyc();
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_8000;
        data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF; data_sram_size = 2;
        #1 chk("wr addr_ok", data_sram_addr_ok, 1);
        chk("wr awvalid early", awvalid, 0);
        cyc();
        data_sram_req = 0; data_sram_wr = 0; data_sram_wdata = 0; awready = 1;
        #1 chk("wr awvalid", awvalid, 1);
        chk("wr wvalid", wvalid, 1);
        chk("wr aw fields", {awaddr, awsize}, {32'h1C00_8000, 3'd2});
        chk("wr w fields", {wdata, wstrb}, {32'h1234_5678, 4'hF});
        cyc();
        #1 chk("wr awvalid dropped", awvalid, 0);
        chk("wr wvalid held", wvalid, 1);
        cyc();
        wready = 1;
        #1 chk("wr wvalid at wready", wvalid, 1);
        chk("wr no bready yet", bready, 0);
        cyc();
        wready = 0; awready = 0;
        #1 chk("wr wvalid dropped", wvalid, 0);
        chk("wr bready", bready, 1);
        chk("wr no data_ok", data_sram_data_ok, 0);
        cyc();
        bvalid = 1;
        #1 chk("wr data_ok", data_sram_data_ok, 1);
        cyc();
        bvalid = 0;
        #1 chk("wr bready idle", bready, 0);

        // Read hitting a pending write address waits for the B handshake
        cyc();
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_8004;
        data_sram_wdata = 32'h0BAD_CAFE;
        #1 chk("haz wr addr_ok", data_sram_addr_ok, 1);
        cyc();
        data_sram_wr = 0; data_sram_addr = 32'h1C00_8006; awready = 1; wready = 1;
        #1 chk("haz rd blocked W_REQ", data_sram_addr_ok, 0);
        cyc();
        awready = 0; wready = 0;
        #1 chk("haz rd blocked W_B", data_sram_addr_ok, 0);
        cyc();
        bvalid = 1;
        #1 chk("haz rd blocked at B", data_sram_addr_ok, 0);
        chk("haz wr data_ok", data_sram_data_ok, 1);
        cyc();
        bvalid = 0;
        #1 chk("haz rd addr_ok", data_sram_addr_ok, 1);
        cyc();
        data_sram_req = 0; arready = 1;
        #1 chk("haz rd araddr", araddr, 32'h1C00_8006);
        cyc();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h0BAD_CAFE;
        #1 chk("haz rd data_ok", data_sram_data_ok, 1);
        cyc();
        rvalid = 0;

        // Data R beat and bvalid in the same cycle
        cyc();
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_0100;
        #1 chk("col rd addr_ok", data_sram_addr_ok, 1);
        cyc();
        data_sram_wr = 1; data_sram_addr = 32'h1C00_0200; arready = 1;
        #1 chk("col wr addr_ok", data_sram_addr_ok, 1);
        cyc();
        data_sram_req = 0; data_sram_wr = 0; arready = 0; awready = 1; wready = 1;
        cyc();
        awready = 0; wready = 0; rvalid = 1; rid = 1; rdata = 32'h5555_AAAA; bvalid = 1;
        #1 chk("col rd data_ok", data_sram_data_ok, 1);
        chk("col rdata", data_sram_rdata, 32'h5555_AAAA);
        chk("col bready low", bready, 0);
        cyc();
        rvalid = 0;
        #1 chk("col bready", bready, 1);
        chk("col wr data_ok", data_sram_data_ok, 1);
        cyc();
        bvalid = 0;
        #1 chk("col quiet", data_sram_data_ok, 0);

        // Reset while in R_R abandons the read
        cyc();
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0300;
        cyc();
        inst_sram_req = 0; arready = 1;
        cyc();
        arready = 0;
        #1 chk("rst in R_R", rready, 1);
        cyc();
        reset = 1;
        #1 chk("rst rready", rready, 0);
        cyc();
        reset = 0; rvalid = 1; rid = 0; rdata = 32'h7777_7777;
        #1 chk("rst no data_ok", inst_sram_data_ok, 0);
        chk("rst rready after", rready, 0);
        chk("rst araddr cleared", araddr, 0);
        cyc();
        rvalid = 0;
        rd('{1'b0, 32'h1C00_0400, 2'd2, 32'h0123_4567, 0, 1, 4'd0, 3'd2});

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
